fd_reg: RTL and testbench
=========================

FD_REG -- requirements
Module: fd_reg

Interface
REQ-001 SHALL have parameter INIT_PC, default 32'h0000_3000, which is the D_PC value after reset.
REQ-002 SHALL have parameter TRAP_PC, default 32'h0000_4180, which is the D_PC value loaded on IntReq.
REQ-003 SHALL have parameter IM_LO, default 32'h0000_3000, the lowest legal fetch address.
REQ-004 SHALL have parameter IM_HI, default 32'h0000_6FFC, the highest legal fetch address.
REQ-005 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low.
REQ-007 SHALL have port F_PC, input, 32 bits: current fetch address from the PC stage.
REQ-008 SHALL have port F_Instr, input, 32 bits: instruction word read at F_PC.
REQ-009 SHALL have port F_BD, input, 1 bit: the fetched instruction is in a branch delay slot.
REQ-010 SHALL have port FD_en, input, 1 bit: load enable; 0 means stall and hold.
REQ-011 SHALL have port flush, input, 1 bit: kill the fetched instruction (eret).
REQ-012 SHALL have port IntReq, input, 1 bit: interrupt/exception taken this cycle.
REQ-013 SHALL have outputs D_PC (32), D_Instr (32), D_BD (1), D_ExcCode (5), D_valid (1) and D_stall_cnt (16).

Function
REQ-014 SHALL raise a fetch fault when F_PC[1:0] != 0, when F_PC < IM_LO, or when F_PC > IM_HI.
REQ-015 SHALL, on a fetch fault during a load, capture D_Instr = 0, D_ExcCode = 5'd4 (AdEL), D_valid = 1, D_PC = F_PC and D_BD = F_BD.
REQ-016 SHALL, on a load with no fault, capture F_PC, F_Instr and F_BD, with D_ExcCode = 0 and D_valid = 1.
REQ-017 SHALL apply this priority at each rising edge: IntReq, then flush, then FD_en = 0 (hold), then load.
REQ-018 SHALL, on IntReq, set D_PC = TRAP_PC, D_Instr = 0, D_BD = 0, D_ExcCode = 0 and D_valid = 0, regardless of FD_en or flush.
REQ-019 SHALL, on flush without IntReq, set D_PC = F_PC, D_Instr = 0, D_BD = 0, D_ExcCode = 0 and D_valid = 0, even when FD_en = 0.
REQ-020 SHALL, on hold (FD_en = 0, no flush, no IntReq), keep all D_* registers unchanged.
REQ-021 SHALL make all outputs registered with a latency of exactly 1 cycle from F_* to D_*, with no combinational path from input to output.
REQ-022 SHALL increment D_stall_cnt by 1 on every edge where the hold condition of REQ-020 applies.
REQ-023 SHALL saturate D_stall_cnt at 16'hFFFF with no wrap-around.
REQ-024 SHALL leave D_stall_cnt unchanged on IntReq and flush edges, which are not counted as stalls.
REQ-025 SHALL ignore F_Instr content entirely when a fetch fault is detected.

Reset
REQ-026 SHALL, while reset = 0, asynchronously force D_PC = INIT_PC, D_Instr = 0, D_BD = 0, D_ExcCode = 0, D_valid = 0 and D_stall_cnt = 0.
REQ-027 SHALL, when reset is asserted mid-stall or mid-flush, override all pending updates immediately, without waiting for a clock edge.
REQ-028 SHALL resume normal loading at the first rising edge after reset deasserts.

Verification
REQ-029 Bench SHALL cover the normal load case: F_PC = 0x3004, F_Instr = 0x24010005, FD_en = 1 -> next cycle D_PC = 0x3004, D_Instr = 0x24010005, D_valid = 1, D_ExcCode = 0.
REQ-030 Bench SHALL cover a misaligned fetch: F_PC = 0x3002, F_Instr = 0xFFFFFFFF -> D_Instr = 0, D_ExcCode = 4, D_PC = 0x3002, D_valid = 1.
REQ-031 Bench SHALL cover an out-of-range fetch at F_PC = 0x7000 and F_PC = 0x2FFC -> D_ExcCode = 4 in both cases; F_PC = 0x6FFC -> D_ExcCode = 0.
REQ-032 Bench SHALL cover a 3-cycle stall: FD_en = 0 for 3 edges while F_* changes -> D_* stays unchanged and D_stall_cnt goes 0 -> 3.
REQ-033 Bench SHALL cover simultaneous events: IntReq = 1, flush = 1, FD_en = 0 on one edge -> D_PC = 0x4180, D_valid = 0, D_stall_cnt unchanged; flush = 1 with FD_en = 0 -> D_PC = F_PC, D_Instr = 0.
REQ-034 Bench SHALL cover asynchronous reset: reset driven 0 between clock edges -> outputs reach D_PC = 0x3000 and D_stall_cnt = 0 before the next edge; a forced count of 0xFFFF followed by a stall -> count remains 0xFFFF.

Source files
------------

// File: rtl/fd_reg_if.sv
// Fetch/decode boundary signals: F_* come from the fetch stage, D_* feed decode.
// The slave modport belongs to the pipeline register, the master to whoever drives fetch.
interface fd_reg_if;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic        F_BD;
    logic        FD_en;
    logic        flush;
    logic        IntReq;

    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_BD;
    logic [4:0]  D_ExcCode;
    logic        D_valid;
    logic [15:0] D_stall_cnt;

    modport slave (
        input  F_PC, F_Instr, F_BD, FD_en, flush, IntReq,
        output D_PC, D_Instr, D_BD, D_ExcCode, D_valid, D_stall_cnt
    );

    modport master (
        output F_PC, F_Instr, F_BD, FD_en, flush, IntReq,
        input  D_PC, D_Instr, D_BD, D_ExcCode, D_valid, D_stall_cnt
    );
endinterface

// File: rtl/fd_reg.sv
// Fetch/decode pipeline register with address-error detection, interrupt/flush kill,
// stall hold and a saturating stall counter. All outputs come straight from flops.
module fd_reg #(
    parameter logic [31:0] INIT_PC = 32'h0000_3000,
    parameter logic [31:0] TRAP_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO   = 32'h0000_3000,
    parameter logic [31:0] IM_HI   = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    fd_reg_if.slave     bus
);
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] pc_reg,    pc_next;
    logic [31:0] instr_reg, instr_next;
    logic        bd_reg,    bd_next;
    logic [4:0]  exc_reg,   exc_next;
    logic        valid_reg, valid_next;
    logic [15:0] cnt_reg,   cnt_next;
    logic        fetch_fault;

    assign fetch_fault = (bus.F_PC[1:0] != 2'b00) || (bus.F_PC < IM_LO) || (bus.F_PC > IM_HI);

    always_comb begin
        pc_next    = pc_reg;
        instr_next = instr_reg;
        bd_next    = bd_reg;
        exc_next   = exc_reg;
        valid_next = valid_reg;
        cnt_next   = cnt_reg;
        if (bus.IntReq) begin
            pc_next    = TRAP_PC;
            instr_next = 32'd0;
            bd_next    = 1'b0;
            exc_next   = 5'd0;
            valid_next = 1'b0;
        end else if (bus.flush) begin
            pc_next    = bus.F_PC;
            instr_next = 32'd0;
            bd_next    = 1'b0;
            exc_next   = 5'd0;
            valid_next = 1'b0;
        end else if (!bus.FD_en) begin
            // Only genuine holds count as stalls; the counter sticks at all-ones.
            if (cnt_reg != 16'hFFFF) begin
                cnt_next = cnt_reg + 16'd1;
            end
        end else begin
            pc_next    = bus.F_PC;
            bd_next    = bus.F_BD;
            valid_next = 1'b1;
            if (fetch_fault) begin
                instr_next = 32'd0;
                exc_next   = EXC_ADEL;
            end else begin
                instr_next = bus.F_Instr;
                exc_next   = 5'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg    <= INIT_PC;
            instr_reg <= 32'd0;
            bd_reg    <= 1'b0;
            exc_reg   <= 5'd0;
            valid_reg <= 1'b0;
            cnt_reg   <= 16'd0;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            bd_reg    <= bd_next;
            exc_reg   <= exc_next;
            valid_reg <= valid_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign bus.D_PC        = pc_reg;
    assign bus.D_Instr     = instr_reg;
    assign bus.D_BD        = bd_reg;
    assign bus.D_ExcCode   = exc_reg;
    assign bus.D_valid     = valid_reg;
    assign bus.D_stall_cnt = cnt_reg;
endmodule

// File: tb/tb_fd_reg.sv
// Scoreboard bench for fd_reg: the driver pushes the expected decode-side state for each
// edge, and a monitor pops and compares it just after that edge.
module tb_fd_reg;
    localparam logic [31:0] INIT_PC = 32'h0000_3000;
    localparam logic [31:0] TRAP_PC = 32'h0000_4180;
    localparam logic [31:0] IM_LO   = 32'h0000_3000;
    localparam logic [31:0] IM_HI   = 32'h0000_6FFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    localparam exp_t RST_STATE = '{pc: INIT_PC, instr: 32'd0, bd: 1'b0, exc: 5'd0, valid: 1'b0, cnt: 16'd0};

    logic clk = 1'b0;
    logic reset = 1'b0;
    fd_reg_if bus ();

    fd_reg #(.INIT_PC(INIT_PC), .TRAP_PC(TRAP_PC), .IM_LO(IM_LO), .IM_HI(IM_HI)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    checks = 0;
    int    errors = 0;
    exp_t  exp_q[$];
    string name_q[$];
    exp_t  model;

    function automatic exp_t dut_state();
        exp_t s;
        s.pc    = bus.D_PC;
        s.instr = bus.D_Instr;
        s.bd    = bus.D_BD;
        s.exc   = bus.D_ExcCode;
        s.valid = bus.D_valid;
        s.cnt   = bus.D_stall_cnt;
        return s;
    endfunction

    // Behavioural reference: what decode should see after one edge with these inputs.
    function automatic exp_t ref_next(exp_t cur, logic [31:0] pc, logic [31:0] instr,
                                      logic bd, logic en, logic fl, logic irq);
        exp_t n;
        bit   bad;
        n = cur;
        bad = (pc % 4 != 0) || (pc < IM_LO) || (pc > IM_HI);
        if (irq) begin
            n = '{pc: TRAP_PC, instr: 32'd0, bd: 1'b0, exc: 5'd0, valid: 1'b0, cnt: cur.cnt};
        end else if (fl) begin
            n = '{pc: pc, instr: 32'd0, bd: 1'b0, exc: 5'd0, valid: 1'b0, cnt: cur.cnt};
        end else if (!en) begin
            n.cnt = (cur.cnt == 16'hFFFF) ? cur.cnt : cur.cnt + 16'd1;
        end else if (bad) begin
            n = '{pc: pc, instr: 32'd0, bd: bd, exc: 5'd4, valid: 1'b1, cnt: cur.cnt};
        end else begin
            n = '{pc: pc, instr: instr, bd: bd, exc: 5'd0, valid: 1'b1, cnt: cur.cnt};
        end
        return n;
    endfunction

    task automatic compare(input string nm, input exp_t got, input exp_t exp, input bit loud);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got pc=%h instr=%h bd=%b exc=%0d valid=%b cnt=%h required pc=%h instr=%h bd=%b exc=%0d valid=%b cnt=%h",
                     nm, got.pc, got.instr, got.bd, got.exc, got.valid, got.cnt,
                     exp.pc, exp.instr, exp.bd, exp.exc, exp.valid, exp.cnt);
        end else if (loud) begin
            $display("ok %s pc=%h instr=%h exc=%0d valid=%b cnt=%h",
                     nm, got.pc, got.instr, got.exc, got.valid, got.cnt);
        end
    endtask

    // Monitor: the register presents a new state after every edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            compare(n, dut_state(), e, n != "fill");
        end
    end

    task automatic step(input logic [31:0] pc, input logic [31:0] instr, input logic bd,
                        input logic en, input logic fl, input logic irq, input string nm);
        @(negedge clk);
        bus.F_PC    = pc;
        bus.F_Instr = instr;
        bus.F_BD    = bd;
        bus.FD_en   = en;
        bus.flush   = fl;
        bus.IntReq  = irq;
        model = ref_next(model, pc, instr, bd, en, fl, irq);
        exp_q.push_back(model);
        name_q.push_back(nm);
    endtask

    // Pull reset low between edges and check outputs before the next edge arrives.
    task automatic async_reset(input string nm);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 compare(nm, dut_state(), RST_STATE, 1'b1);
        model = RST_STATE;
        @(negedge clk);
        bus.FD_en = 1'b1;
        exp_q.push_back(RST_STATE);
        name_q.push_back({nm, "_held"});
        @(posedge clk);
        #3 reset = 1'b1;
    endtask

    initial begin
        bus.F_PC = 32'h3000; bus.F_Instr = 32'd0; bus.F_BD = 1'b0;
        bus.FD_en = 1'b1; bus.flush = 1'b0; bus.IntReq = 1'b0;
        model = RST_STATE;
        #12;
        compare("reset_state", dut_state(), RST_STATE, 1'b1);
        @(posedge clk);
        #3 reset = 1'b1;

        step(32'h3004, 32'h2401_0005, 1'b0, 1'b1, 1'b0, 1'b0, "load_normal");
        step(32'h3002, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0, "misaligned");
        step(32'h7000, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, "above_hi");
        step(32'h2FFC, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, "below_lo");
        step(32'h6FFC, 32'h8C01_0000, 1'b1, 1'b1, 1'b0, 1'b0, "at_hi");
        step(32'h3008, 32'hAAAA_5555, 1'b0, 1'b0, 1'b0, 1'b0, "stall1");
        step(32'h300C, 32'h5555_AAAA, 1'b1, 1'b0, 1'b0, 1'b0, "stall2");
        step(32'h3010, 32'h0F0F_0F0F, 1'b0, 1'b0, 1'b0, 1'b0, "stall3");
        step(32'h3014, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 1'b1, "irq_flush_stall");
        step(32'h3018, 32'h2222_2222, 1'b1, 1'b0, 1'b1, 1'b0, "flush_stall");
        step(32'h301C, 32'h3333_3333, 1'b0, 1'b1, 1'b0, 1'b0, "load_after_flush");
        step(32'h3020, 32'h4444_4444, 1'b0, 1'b0, 1'b0, 1'b0, "stall_pre_rst");
        async_reset("async_rst_mid_stall");
        step(32'h3024, 32'h2401_0005, 1'b0, 1'b1, 1'b0, 1'b0, "load_after_rst");

        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            case ($urandom_range(0, 5))
                0: pc = IM_LO + 4 * $urandom_range(0, (IM_HI - IM_LO) / 4);
                1: pc = IM_LO + 4 * $urandom_range(0, 64) + $urandom_range(1, 3);
                2: pc = IM_LO - 4 * $urandom_range(1, 64);
                3: pc = IM_HI + 4 * $urandom_range(1, 64);
                4: pc = IM_LO;
                default: pc = IM_HI;
            endcase
            step(pc, $urandom, 1'($urandom), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 9) == 0), "rand");
        end

        async_reset("async_rst_pre_sat");
        for (int i = 0; i < 65535; i++) begin
            step(32'h3000 + 32'(4 * (i % 16)), $urandom, 1'b0, 1'b0, 1'b0, 1'b0, "fill");
        end
        step(32'h3040, 32'h9999_9999, 1'b0, 1'b0, 1'b0, 1'b0, "stall_at_sat");
        step(32'h3044, 32'h8888_8888, 1'b0, 1'b0, 1'b0, 1'b0, "stall_at_sat2");
        step(32'h3048, 32'h7777_7777, 1'b1, 1'b1, 1'b0, 1'b0, "load_at_sat");

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
